fp32_to_int_seq: RTL and testbench
==================================

Name: fp32_to_int_seq

Overview:
- Multi-cycle converter from IEEE-754 single precision to signed 32-bit integer.
- Rounds toward zero, which is C cast semantics.
- It is the return path from the floating-point datapath back to the integer ALU, the reverse of the FP adder's integer-mantissa-to-IEEE packing.
- Uses a valid/ready handshake on both sides and an iterative 1-bit-per-cycle shifter to keep area small.

Parameters:
N, 32, operand and result width; only 32 is supported (8-bit exponent, 23-bit fraction, bias 127).

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_data valid
in_ready  output  1  block can accept an operand (high only in IDLE)
in_data  input  N  IEEE-754 single operand
out_valid  output  1  out_data/out_flags valid
out_ready  input  1  consumer accepts result
out_data  output  N  signed two's-complement result
out_flags  output  3  {invalid, overflow, inexact}

Behaviour:
- Reset state: state=IDLE, out_valid=0, out_data=0, out_flags=0, internal count/magnitude/sticky=0.
- in_ready = (state==IDLE). It is combinational from state, so it reads 1 while rst is high, but inputs are ignored while rst is high.
- States: IDLE, SHIFT, DONE.

Accept (IDLE, in_valid && in_ready at the rising edge):
- Register sign s, exponent E, fraction F. Let e = E-127.
- Classify, first match wins:
  - NaN (E=255, F!=0): result 0x7FFFFFFF, invalid=1.
  - Inf (E=255, F=0): result 0x7FFFFFFF if s=0, else 0x80000000; overflow=1.
  - E=158, s=1, F=0 (exactly -2^31): result 0x80000000, flags 0.
  - E>=158: saturate as for Inf; overflow=1.
  - E<127 (|x|<1, includes zeros and denormals): result 0. inexact=1 iff (E!=0 or F!=0). ±0 gives 0, flags 0.
  - Otherwise (e in 0..30): mag = {8'b0,1'b1,F}. If e<23, right shift, count=23-e. If e>23, left shift, count=e-23. If e=23, count=0.
- All special cases load count=0 with the final result preset.
- Next state is SHIFT.

SHIFT:
- Each edge with count!=0: shift mag one bit in the stored direction and decrement count.
- On right shifts, sticky |= the bit shifted out.
- Edge with count==0: latch out_data = s ? -mag : mag (special cases keep the preset value). Set inexact |= sticky, out_valid=1, next state DONE.

DONE:
- out_data and out_flags are held stable while out_valid=1 and out_ready=0.
- On out_valid && out_ready: out_valid=0, next state IDLE.
- in_ready=0, so a new operand cannot be accepted in the same cycle as the output is consumed. It is accepted in IDLE the following cycle.

Latency:
- out_valid rises count+1 edges after the accept edge.
- Special cases: 1 edge.
- Maximum: 24 edges (e=0, i.e. 1.0 <= |x| < 2).

Other rules:
- One operand in flight; there is no overlap.
- Maximum left shift is 7 (e=30). The magnitude never exceeds 2^31-1 on the normal path, so negation cannot overflow.
- Asynchronous reset asserted mid-SHIFT or mid-DONE aborts immediately: out_valid drops to 0 and the pending result is discarded. After release the block is in IDLE with in_ready=1.
- out_ready is ignored outside DONE.
- in_data and in_valid are ignored outside IDLE.

Test Plan:
- in_data=0x3F800000 (1.0), out_ready=1 -> out_data=0x00000001, flags=000, out_valid rises exactly 24 edges after accept; in_ready low throughout.
- 0xC0200000 (-2.5) -> 0xFFFFFFFE, flags=001 (inexact), latency 23. Then 0x4E800000 (2^30) -> 0x40000000, flags=000, latency 8.
- 0xCF000000 -> 0x80000000, flags=000. 0x4F000000 -> 0x7FFFFFFF, flags=010. 0xFF800000 -> 0x80000000, flags=010. 0x7FC00000 -> 0x7FFFFFFF, flags=100. Each has latency 1.
- 0x3F400000 (0.75) -> 0x00000000, flags=001. 0x80000000 (-0.0) -> 0x00000000, flags=000. 0x00000001 (denormal) -> 0, flags=001.
- Backpressure: convert 0x41200000 (10.0) with out_ready=0 for 5 cycles -> out_valid stays 1, out_data=0x0000000A stable, in_ready=0. Raise out_ready -> out_valid=0 the next edge, then in_ready=1.
- Reset mid-operation: accept 0x3F800000, assert rst after 5 cycles -> out_valid=0, out_data=0, flags=0 immediately (asynchronous). Release rst, then convert 0x42F60000 (123.0) -> 0x0000007B, flags=000, latency 18.

Source files
------------

// File: rtl/fp32_to_int_seq.sv
// -----------------------------------------------------------------------------
// fp32_to_int_seq
//
// Multi-cycle IEEE-754 single precision to signed 32-bit integer converter,
// rounding toward zero (C cast semantics). Returns results from the FP
// datapath to the integer ALU. A single iterative 1-bit-per-cycle shifter
// aligns the significand, so only one operand is in flight at a time.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   in_data valid
//   in_ready   block can accept an operand (high only in IDLE)
//   in_data    IEEE-754 single operand
//   out_valid  out_data/out_flags valid
//   out_ready  consumer accepts result
//   out_data   signed two's-complement result
//   out_flags  {invalid, overflow, inexact}
// -----------------------------------------------------------------------------
module fp32_to_int_seq #(
  parameter int N = 32  // only 32 is supported
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [2:0]   out_flags
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} stateType;

  localparam logic [7:0] EXP_MAX      = 8'd255;
  localparam logic [7:0] EXP_INT_MIN  = 8'd158;  // 2^31: first unrepresentable magnitude
  localparam logic [7:0] EXP_ONE      = 8'd127;  // bias
  localparam logic [7:0] EXP_ALIGNED  = 8'd150;  // e = 23: fraction already integer-aligned

  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  stateType state, nextState;

  logic        signBit;
  logic        shiftLeft;
  logic        isSpecial;  // result was preset at accept; skip the negate/latch
  logic        sticky;
  logic [4:0]  count;
  logic [31:0] mag;

  // Operand fields
  logic        inSign;
  logic [7:0]  inExp;
  logic [22:0] inFrac;
  assign inSign = in_data[31];
  assign inExp  = in_data[30:23];
  assign inFrac = in_data[22:0];

  // Classification of the incoming operand
  logic        clsSpecial;
  logic [31:0] clsData;
  logic [2:0]  clsFlags;
  logic        clsLeft;
  logic [4:0]  clsCount;

  logic accept;
  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (in_valid)      nextState = SHIFT;
      SHIFT:   if (count == 5'd0) nextState = DONE;
      DONE:    if (out_ready)     nextState = IDLE;
      default:                    nextState = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand classification (first match wins)
  // ---------------------------------------------------------------------------
  always_comb begin
    clsSpecial = 1'b1;
    clsData    = 32'd0;
    clsFlags   = 3'b000;
    clsLeft    = 1'b0;
    clsCount   = 5'd0;
    if (inExp == EXP_MAX && inFrac != 23'd0) begin
      clsData  = INT_MAX;                        // NaN
      clsFlags = 3'b100;
    end else if (inExp == EXP_MAX) begin
      clsData  = inSign ? INT_MIN : INT_MAX;     // +/-Inf
      clsFlags = 3'b010;
    end else if (inExp == EXP_INT_MIN && inSign && inFrac == 23'd0) begin
      clsData  = INT_MIN;                        // exactly -2^31 is representable
    end else if (inExp >= EXP_INT_MIN) begin
      clsData  = inSign ? INT_MIN : INT_MAX;     // out of range: saturate
      clsFlags = 3'b010;
    end else if (inExp < EXP_ONE) begin
      // |x| < 1 truncates to zero; only exact zeros are exact
      clsFlags = {2'b00, (inExp != 8'd0) || (inFrac != 23'd0)};
    end else begin
      clsSpecial = 1'b0;
      if (inExp > EXP_ALIGNED) begin
        clsLeft  = 1'b1;
        clsCount = 5'(inExp - EXP_ALIGNED);      // e - 23, at most 7
      end else begin
        clsCount = 5'(EXP_ALIGNED - inExp);      // 23 - e, zero when aligned
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      signBit   <= 1'b0;
      shiftLeft <= 1'b0;
      isSpecial <= 1'b0;
      sticky    <= 1'b0;
      count     <= 5'd0;
      mag       <= 32'd0;
      out_valid <= 1'b0;
      out_data  <= 32'd0;
      out_flags <= 3'b000;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            signBit   <= inSign;
            shiftLeft <= clsLeft;
            isSpecial <= clsSpecial;
            sticky    <= 1'b0;
            count     <= clsCount;
            mag       <= clsSpecial ? 32'd0 : {8'b0, 1'b1, inFrac};
            out_flags <= clsFlags;
            if (clsSpecial) out_data <= clsData;
          end
        end
        SHIFT: begin
          if (count != 5'd0) begin
            count <= count - 5'd1;
            if (shiftLeft) begin
              mag <= {mag[30:0], 1'b0};
            end else begin
              mag    <= {1'b0, mag[31:1]};
              sticky <= sticky | mag[0];
            end
          end else begin
            // Normal-path magnitude is below 2^31, so negation cannot overflow
            if (!isSpecial) out_data <= signBit ? (~mag + 32'd1) : mag;
            out_flags[0] <= out_flags[0] | sticky;
            out_valid    <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_to_int_seq.sv
// -----------------------------------------------------------------------------
// tb_fp32_to_int_seq
//
// Directed self-checking bench for fp32_to_int_seq. Each step drives an
// operand, measures edges from accept to out_valid, and checks result, flags
// and handshake signals against hand-computed values.
// -----------------------------------------------------------------------------
module tb_fp32_to_int_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_flags;

  int nCompared   = 0;
  int nMismatched = 0;

  fp32_to_int_seq #(.N(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    nCompared++;
    assert (observed === expected)
    else begin
      nMismatched++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Issue one operand from IDLE, wait for out_valid (bounded), check
  // latency/result/flags. If out_ready is high, also check the consume edge.
  task automatic convert(input string tag, input logic [31:0] din,
                         input logic [31:0] expData, input logic [2:0] expFlags,
                         input int expLat);
    int   lat;
    logic readyLow;
    check({tag, " idle in_ready"}, 32'(in_ready), 32'd1);
    in_data  = din;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
    lat      = 0;
    readyLow = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready) readyLow = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"},  32'(lat),       32'(expLat));
    check({tag, " data"},     out_data,       expData);
    check({tag, " flags"},    32'(out_flags), 32'(expFlags));
    check({tag, " busy ready"}, 32'(readyLow && !in_ready), 32'd1);
    if (out_ready) begin
      @(posedge clk); #1;
      check({tag, " consumed valid"}, 32'(out_valid), 32'd0);
      check({tag, " back to idle"},   32'(in_ready),  32'd1);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;           // ignored while in reset
    in_data   = 32'h3F80_0000;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data",  out_data,       32'd0);
    check("reset out_flags", 32'(out_flags), 32'd0);
    check("reset in_ready",  32'(in_ready),  32'd1);
    in_valid = 1'b0;
    rst      = 1'b0;
    @(posedge clk); #1;
    check("post-reset idle valid", 32'(out_valid), 32'd0);

    // Normal path: right shifts, left shifts, rounding toward zero
    convert("one",     32'h3F80_0000, 32'h0000_0001, 3'b000, 24);
    convert("m2p5",    32'hC020_0000, 32'hFFFF_FFFE, 3'b001, 23);
    convert("two30",   32'h4E80_0000, 32'h4000_0000, 3'b000, 8);

    // Special cases, all one edge
    convert("minint",  32'hCF00_0000, 32'h8000_0000, 3'b000, 1);
    convert("pos2p31", 32'h4F00_0000, 32'h7FFF_FFFF, 3'b010, 1);
    convert("neginf",  32'hFF80_0000, 32'h8000_0000, 3'b010, 1);
    convert("nan",     32'h7FC0_0000, 32'h7FFF_FFFF, 3'b100, 1);
    convert("p075",    32'h3F40_0000, 32'h0000_0000, 3'b001, 1);
    convert("negzero", 32'h8000_0000, 32'h0000_0000, 3'b000, 1);
    convert("denorm",  32'h0000_0001, 32'h0000_0000, 3'b001, 1);

    // Backpressure: result held while out_ready is low
    out_ready = 1'b0;
    convert("ten", 32'h4120_0000, 32'h0000_000A, 3'b000, 21);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold valid",    32'(out_valid), 32'd1);
      check("hold data",     out_data,       32'h0000_000A);
      check("hold in_ready", 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release valid",    32'(out_valid), 32'd0);
    check("release in_ready", 32'(in_ready),  32'd1);

    // Asynchronous reset mid-SHIFT discards the operation immediately
    in_data  = 32'h3F80_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort out_data",  out_data,       32'd0);
    check("abort out_flags", 32'(out_flags), 32'd0);
    check("abort in_ready",  32'(in_ready),  32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    convert("after abort", 32'h42F6_0000, 32'h0000_007B, 3'b000, 18);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
